// File: rtl/cnn_pkg.sv
// Shared types and constants for the CNN weight-loading path.
package cnn_pkg;

  localparam int unsigned FILT_DIM        = 5;
  localparam int unsigned FILT_WORDS      = FILT_DIM * FILT_DIM;
  localparam int unsigned DEF_MAX_FILTERS = 1920;
  localparam int unsigned DEF_MAX_BIAS    = 120;
  localparam int unsigned DEF_FIN_TIMEOUT = 255;

  typedef logic signed [15:0] word_t;
  typedef word_t [FILT_DIM-1:0][FILT_DIM-1:0] filter_t;

  typedef enum logic [3:0] {
    StIdle,
    StBiasCollect,
    StBiasStrobe,
    StBiasGap,
    StFiltCollect,
    StFiltStrobe,
    StFiltWait,
    StFiltGap,
    StDone
  } loader_state_e;

  // Saturate a requested count at the buffer depth.
  function automatic logic [15:0] clamp_count(input logic [15:0] val, input logic [15:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/filter_assembler_5x5.sv
// Collects 25 stream words into a 5x5 filter in row-major order.
module filter_assembler_5x5
  import cnn_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    load_i,
  input  word_t   data_i,
  output filter_t filter_o,
  output logic    last_o
);

  logic [4:0] word_cnt_q;
  logic [2:0] row_q;
  logic [2:0] col_q;
  filter_t    filter_q;

  assign last_o   = (word_cnt_q == 5'(FILT_WORDS - 1));
  assign filter_o = filter_q;

  // Write each accepted word; counters return to zero after the 25th word.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_cnt_q <= '0;
      row_q      <= '0;
      col_q      <= '0;
      filter_q   <= '0;
    end else if (load_i) begin
      filter_q[row_q][col_q] <= data_i;
      if (last_o) begin
        word_cnt_q <= '0;
        row_q      <= '0;
        col_q      <= '0;
      end else begin
        word_cnt_q <= word_cnt_q + 5'd1;
        if (col_q == 3'(FILT_DIM - 1)) begin
          col_q <= '0;
          row_q <= row_q + 3'd1;
        end else begin
          col_q <= col_q + 3'd1;
        end
      end
    end
  end

endmodule

// File: rtl/filter_loader_5x5.sv
// Streams bias words and 5x5 filters into the filter buffer with a read/finish handshake.
module filter_loader_5x5
  import cnn_pkg::*;
#(
  parameter int unsigned MAX_FILTERS = DEF_MAX_FILTERS,
  parameter int unsigned MAX_BIAS    = DEF_MAX_BIAS,
  parameter int unsigned FIN_TIMEOUT = DEF_FIN_TIMEOUT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [15:0]                num_filters,
  input  logic [15:0]                num_bias,
  input  word_t                      s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       read,
  output logic                       bias_or_filter,
  output logic [15:0]                index_buffer,
  output filter_t                    input_filter,
  output word_t [MAX_BIAS-1:0]       input_bias,
  input  logic                       finish,
  output logic                       busy,
  output logic                       done,
  output logic                       error
);

  localparam logic [15:0] MaxFilt16 = 16'(MAX_FILTERS);
  localparam logic [15:0] MaxBias16 = 16'(MAX_BIAS);
  localparam int unsigned BiasIdxW  = (MAX_BIAS > 1) ? $clog2(MAX_BIAS) : 1;
  localparam int unsigned WaitW     = $clog2(FIN_TIMEOUT + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(FIN_TIMEOUT - 1);

  loader_state_e        state_q, state_d;
  logic [15:0]          nf_q, nb_q;
  logic [15:0]          bias_cnt_q;
  logic [15:0]          idx_q;
  logic [WaitW-1:0]     wait_cnt_q;
  logic                 error_q, bof_q, done_q;
  word_t [MAX_BIAS-1:0] bias_q;

  logic [15:0] nf_clamp, nb_clamp, idx_next;
  logic        xfer, bias_last, filt_last, filt_load, timeout;

  assign nf_clamp  = clamp_count(num_filters, MaxFilt16);
  assign nb_clamp  = clamp_count(num_bias, MaxBias16);
  assign idx_next  = idx_q + 16'd1;
  assign xfer      = s_valid && s_ready;
  assign bias_last = (bias_cnt_q == nb_q - 16'd1);
  assign filt_load = xfer && (state_q == StFiltCollect);
  assign timeout   = (wait_cnt_q == WaitLast);

  filter_assembler_5x5 u_assembler (
    .clk_i    (clk),
    .rst_i    (rst),
    .load_i   (filt_load),
    .data_i   (s_data),
    .filter_o (input_filter),
    .last_o   (filt_last)
  );

  assign s_ready        = (state_q == StBiasCollect) || (state_q == StFiltCollect);
  // Filter strobe is visible from FILT_WAIT so FILT_STROBE acts as a setup cycle.
  assign read           = (state_q == StBiasStrobe) || (state_q == StFiltWait);
  assign busy           = (state_q != StIdle);
  assign done           = done_q;
  assign error          = error_q;
  assign bias_or_filter = bof_q;
  assign index_buffer   = idx_q;
  assign input_bias     = bias_q;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (nb_clamp != '0)      state_d = StBiasCollect;
          else if (nf_clamp != '0) state_d = StFiltCollect;
          else                     state_d = StDone;
        end
      end
      StBiasCollect: if (xfer && bias_last) state_d = StBiasStrobe;
      StBiasStrobe:  state_d = StBiasGap;
      StBiasGap:     state_d = (nf_q != '0) ? StFiltCollect : StDone;
      StFiltCollect: if (xfer && filt_last) state_d = StFiltStrobe;
      StFiltStrobe:  state_d = StFiltWait;
      StFiltWait: begin
        if (finish)       state_d = StFiltGap;
        else if (timeout) state_d = StDone;
      end
      StFiltGap:     state_d = (idx_next == nf_q) ? StDone : StFiltCollect;
      StDone:        state_d = StIdle;
      default:       state_d = StIdle;
    endcase
  end

  // State, counters, bias capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      nf_q       <= '0;
      nb_q       <= '0;
      bias_cnt_q <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      error_q    <= 1'b0;
      bof_q      <= 1'b1;
      done_q     <= 1'b0;
      bias_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == StDone);
      if (state_q == StIdle && start) begin
        nf_q       <= nf_clamp;
        nb_q       <= nb_clamp;
        bias_cnt_q <= '0;
        idx_q      <= '0;
        error_q    <= 1'b0;
        // Bias select is settled long before the bias strobe.
        bof_q      <= (nb_clamp == '0);
      end
      if (state_q == StBiasCollect && xfer) begin
        bias_q[bias_cnt_q[BiasIdxW-1:0]] <= s_data;
        bias_cnt_q <= bias_cnt_q + 16'd1;
      end
      if (state_q == StFiltCollect && state_d == StFiltStrobe) bof_q <= 1'b1;
      wait_cnt_q <= (state_q == StFiltWait) ? wait_cnt_q + 1'b1 : '0;
      if (state_q == StFiltWait && !finish && timeout) error_q <= 1'b1;
      if (state_q == StFiltGap) idx_q <= idx_next;
    end
  end

endmodule

// File: tb/tb_filter_loader_5x5.sv
// Directed bench for filter_loader_5x5 with a write-level reference model.
module tb_filter_loader_5x5;
  import cnn_pkg::*;

  localparam int MaxBias    = 120;
  localparam int MaxFilters = 1920;
  localparam int FinTimeout = 255;

  logic                clk = 1'b0;
  logic                rst, start, s_valid, s_ready, read, bias_or_filter, finish;
  logic                busy, done, error;
  logic [15:0]         num_filters, num_bias, index_buffer;
  word_t               s_data;
  filter_t             input_filter;
  word_t [MaxBias-1:0] input_bias;

  filter_loader_5x5 dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_filters    (num_filters),
    .num_bias       (num_bias),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .read           (read),
    .bias_or_filter (bias_or_filter),
    .index_buffer   (index_buffer),
    .input_filter   (input_filter),
    .input_bias     (input_bias),
    .finish         (finish),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                  is_filter;
    int                  idx;
    int                  words;
    int                  len;
    filter_t             filt;
    word_t [MaxBias-1:0] bvec;
  } wr_t;

  int    checks = 0;
  int    errors = 0;
  wr_t   exp_q[$];
  word_t stream_q[$];
  word_t m_bias[MaxBias];
  int    exp_done = 0;
  bit    exp_err = 1'b0;
  int    fin_delay = 1;
  bit    valid_toggle = 1'b0;
  int    n_reads = 0;
  int    n_done = 0;
  int    words = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Expected buffer writes for one load, derived from counts and the word stream.
  task automatic plan(input int nb, input int nf, input int fd, input int base, output int nw);
    int  b, f, w;
    wr_t e;
    b = (nb > MaxBias) ? MaxBias : nb;
    f = (nf > MaxFilters) ? MaxFilters : nf;
    w = base;
    if (b > 0) begin
      for (int i = 0; i < b; i++) begin
        m_bias[i] = word_t'(w);
        w++;
      end
      e.is_filter = 1'b0; e.idx = 0; e.words = b; e.len = 1; e.filt = '0;
      for (int i = 0; i < MaxBias; i++) e.bvec[i] = m_bias[i];
      exp_q.push_back(e);
    end
    for (int k = 0; k < f; k++) begin
      e.is_filter = 1'b1; e.idx = k; e.words = 25;
      e.len = (fd < 0) ? FinTimeout : ((fd == 0) ? 1 : fd);
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 5; c++) begin
          e.filt[r][c] = word_t'(w);
          w++;
        end
      exp_q.push_back(e);
      if (fd < 0) break;
    end
    exp_done = exp_done + 1;
    exp_err  = (fd < 0) && (f > 0);
    nw = w - base;
  endtask

  // Stream source: commits a word once the handshake seen before the edge completes.
  initial begin
    bit pend, ph;
    s_valid = 1'b0; s_data = '0; ph = 1'b0;
    forever begin
      @(negedge clk);
      pend = s_valid && s_ready && !rst;
      @(posedge clk); #1;
      if (pend && stream_q.size() > 0) void'(stream_q.pop_front());
      ph = ~ph;
      s_valid = (stream_q.size() > 0) && (!valid_toggle || ph);
      s_data  = (stream_q.size() > 0) ? stream_q[0] : '0;
    end
  end

  // Buffer responder: acknowledges a filter write fin_delay cycles into read (never if < 0).
  initial begin
    int rcnt;
    finish = 1'b0; rcnt = 0;
    forever begin
      @(negedge clk);
      if (read && bias_or_filter) rcnt++;
      else rcnt = 0;
      finish = (fin_delay >= 0) && (rcnt >= fin_delay);
    end
  end

  // Compare process: every strobe and done pulse against the model.
  initial begin
    wr_t         cur;
    bit          prev_read, prev_done, prev_bof, cap_bof, hold_ok;
    filter_t     prev_filt, cap_filt;
    logic [15:0] prev_idx, cap_idx;
    int          rlen, bad, br, bc;
    prev_read = 0; prev_done = 0; prev_bof = 1; rlen = 0; hold_ok = 1;
    prev_filt = '0; prev_idx = '0; cap_filt = '0; cap_idx = '0; cap_bof = 1;
    cur.len = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_read = 0; prev_done = 0; words = 0;
        continue;
      end
      if (read && !prev_read) begin
        n_reads++;
        if (exp_q.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          check("strobe_kind", bias_or_filter, cur.is_filter);
          check("strobe_index", index_buffer, cur.idx);
          check("strobe_words", words, cur.words);
          if (cur.is_filter) begin
            check("setup_stable", (prev_filt === input_filter) && (prev_idx === index_buffer)
                  && (prev_bof === bias_or_filter), 1);
            br = 0; bc = 0;
            for (int r = 0; r < 5; r++)
              for (int c = 0; c < 5; c++)
                if (input_filter[r][c] !== cur.filt[r][c]) begin br = r; bc = c; end
            check($sformatf("filter[%0d][%0d]", br, bc), input_filter[br][bc],
                  cur.filt[br][bc]);
          end else begin
            bad = 0;
            for (int i = 0; i < MaxBias; i++)
              if (input_bias[i] !== cur.bvec[i]) bad = i;
            check($sformatf("bias[%0d]", bad), input_bias[bad], cur.bvec[bad]);
          end
        end
        words = 0; rlen = 1; hold_ok = 1;
        cap_filt = input_filter; cap_idx = index_buffer; cap_bof = bias_or_filter;
      end else if (read) begin
        rlen++;
        if (input_filter !== cap_filt || index_buffer !== cap_idx || bias_or_filter !== cap_bof)
          hold_ok = 0;
      end
      if (!read && prev_read) begin
        check("strobe_len", rlen, cur.len);
        check("strobe_hold", hold_ok, 1);
      end
      if (done) begin
        n_done++;
        check("done_expected", exp_done > 0, 1);
        if (exp_done > 0) exp_done--;
        check("done_error", error, exp_err);
        check("done_single", prev_done, 0);
      end
      if (s_valid && s_ready) words++;
      prev_read = read; prev_done = done;
      prev_filt = input_filter; prev_idx = index_buffer; prev_bof = bias_or_filter;
    end
  end

  task automatic run_load(input int nb, input int nf, input int fd, input bit toggle,
                          input int extra, input int base, input int poke);
    int nw, c;
    stream_q.delete();
    plan(nb, nf, fd, base, nw);
    for (int i = 0; i < nw + extra; i++) stream_q.push_back(word_t'(base + i));
    fin_delay = fd; valid_toggle = toggle;
    num_bias = 16'(nb); num_filters = 16'(nf); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (exp_done > 0 && c < 5000) begin
      // A start while busy must be ignored.
      if (poke > 0 && c == poke) begin num_filters = 16'd5; start = 1'b1; end
      else start = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    check("done_seen", exp_done, 0);
    check("writes_left", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int nw, c, r0, d0;
    rst = 1'b1; start = 1'b0; num_filters = '0; num_bias = '0;
    for (int i = 0; i < MaxBias; i++) m_bias[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read", read, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_index", index_buffer, 0);
    check("rst_bias_or_filter", bias_or_filter, 1);
    check("rst_filter_zero", input_filter === '0, 1);
    check("rst_bias_zero", input_bias === '0, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two bias words, one filter, finish two cycles into read.
    run_load(2, 1, 2, 1'b0, 0, 1, 0);
    check("a_bias0", input_bias[0], 1);
    check("a_bias1", input_bias[1], 2);
    check("a_filt00", input_filter[0][0], 3);
    check("a_filt44", input_filter[4][4], 27);
    check("a_index_end", index_buffer, 1);

    // Finish already high on the first wait cycle; negative words.
    run_load(3, 2, 0, 1'b0, 0, -30, 0);
    check("b_filt44", input_filter[4][4], 22);
    check("b_bias2", input_bias[2], -28);
    check("b_bias3", input_bias[3], 0);
    check("b_index_end", index_buffer, 2);

    // Gappy stream, three filters, stray start mid-load.
    r0 = n_reads;
    run_load(0, 3, 1, 1'b1, 0, 200, 10);
    check("c_read_pulses", n_reads - r0, 3);
    check("c_error", error, 0);

    // Finish never returns: timeout.
    run_load(0, 2, -1, 1'b0, 25, 100, 0);
    check("d_error", error, 1);
    check("d_read", read, 0);
    check("d_busy", busy, 0);

    // Zero-length load: done two cycles after start, error cleared by start.
    stream_q.delete();
    r0 = n_reads;
    plan(0, 0, 1, 0, nw);
    num_bias = '0; num_filters = '0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("e_error_cleared", error, 0);
    check("e_done_early", done, 0);
    check("e_busy", busy, 1);
    @(posedge clk); #1;
    check("e_done_pulse", done, 1);
    @(posedge clk); #1;
    check("e_done_end", done, 0);
    check("e_no_read", n_reads - r0, 0);

    // Bias count beyond depth is clamped.
    run_load(200, 0, 1, 1'b0, 5, 1000, 0);
    check("f_words_left", stream_q.size(), 5);
    check("f_bias119", input_bias[119], 1119);
    check("f_s_ready", s_ready, 0);

    // Abort with reset during the 10th word of filter 1.
    stream_q.delete();
    plan(0, 2, 1, 500, nw);
    for (int i = 0; i < nw; i++) stream_q.push_back(word_t'(500 + i));
    fin_delay = 1; valid_toggle = 1'b0;
    num_bias = '0; num_filters = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    r0 = n_reads; c = 0;
    while (!((n_reads - r0) >= 1 && words == 9 && s_ready) && c < 3000) begin
      @(posedge clk); #1;
      c++;
    end
    check("g_reached", c < 3000, 1);
    check("g_index_before", index_buffer, 1);
    d0 = n_done;
    rst = 1'b1;
    exp_q.delete(); exp_done = 0; stream_q.delete();
    for (int i = 0; i < MaxBias; i++) m_bias[i] = '0;
    @(posedge clk); #1;
    check("g_read", read, 0);
    check("g_busy", busy, 0);
    check("g_index", index_buffer, 0);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("g_no_done", n_done - d0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
